// File: rtl/sc_stream_to_fp.sv
// rtl/sc_stream_to_fp.sv - stochastic bitstream to IEEE-754 single decoder
// Optional sample qualifier bit_valid enabled by defining SC_DEC_STALL_EN.
module sc_stream_to_fp #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic        bit_in,
`ifdef SC_DEC_STALL_EN
  input  logic        bit_valid,
`endif
  output logic [31:0] P,
  output logic        done
);

  localparam int PAD = 23 - N;

  typedef enum logic [1:0] {IDLE, COUNT, NORM, DONE} state_t;

  state_t             state, state_nxt;
  logic [N:0]         ones;
  logic [N:0]         m;
  logic [N-1:0]       cyc;
  logic signed [9:0]  e;
  logic               sign_q;
  logic [7:0]         exp_q;
  logic               sample_en;
  logic               last_sample;
  logic               norm_fin;
  logic [22:0]        frac;
  logic [31:0]        result;

`ifdef SC_DEC_STALL_EN
  assign sample_en = bit_valid;
`else
  assign sample_en = 1'b1;
`endif

  assign last_sample = (state == COUNT) && sample_en && (cyc == '1);
  assign norm_fin    = (state == NORM) && ((m == '0) || m[N]);

  // Bits below the leading one become the fraction, left-aligned and truncated.
  assign frac = 23'(m[N-1:0]) << PAD;

  always_comb begin
    result = {sign_q, e[7:0], frac};
    if (m == '0 || e <= 10'sd0)
      result = {sign_q, 31'b0};
    else if (e >= 10'sd255)
      result = {sign_q, 8'hFF, 23'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = COUNT;
      COUNT:      if (last_sample) state_nxt = NORM;
      NORM:       if (norm_fin) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones   <= '0;
      cyc    <= '0;
      m      <= '0;
      e      <= '0;
      sign_q <= 1'b0;
      exp_q  <= 8'd0;
      P      <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sign_q <= sign_in;
            exp_q  <= exp_in;
            ones   <= '0;
            cyc    <= '0;
          end
        end
        COUNT: begin
          if (sample_en) begin
            ones <= ones + (N+1)'(bit_in);
            cyc  <= cyc + 1'b1;
            if (cyc == '1) begin
              m <= ones + (N+1)'(bit_in);
              e <= signed'({2'b00, exp_q});
            end
          end
        end
        NORM: begin
          if (norm_fin) begin
            P <= result;
          end else begin
            m <= m << 1;
            e <= e - 10'sd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_to_fp.sv
// tb/tb_sc_stream_to_fp.sv - scoreboard bench for sc_stream_to_fp
// Stall scenario is exercised only when SC_DEC_STALL_EN is defined.
`timescale 1ns/1ps
module tb_sc_stream_to_fp;

  localparam int N = 8;
  localparam int L = 1 << N;

  typedef struct {
    logic [31:0] p;
    int          lat;
    int          start_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = 8'd0;
  logic        bit_in = 1'b0;
`ifdef SC_DEC_STALL_EN
  logic        bit_valid = 1'b1;
`endif
  logic [31:0] P;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  logic        done_q = 1'b0;
  logic [31:0] last_p = 32'd0;
  logic        stream [0:L-1];
  exp_t        sb [$];

  sc_stream_to_fp #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sign_in(sign_in),
    .exp_in(exp_in),
    .bit_in(bit_in),
`ifdef SC_DEC_STALL_EN
    .bit_valid(bit_valid),
`endif
    .P(P),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: value = (-1)^sign * ones/2^N * 2^(exp-127), truncated to single precision.
  function automatic logic [31:0] model(input logic sg, input logic [7:0] ex, input int ones);
    int k;
    int ev;
    logic [22:0] fr;
    if (ones == 0) return {sg, 31'b0};
    k  = $clog2(ones + 1) - 1;
    ev = int'(ex) - (N - k);
    fr = 23'((ones - (1 << k)) << (23 - k));
    if (ev <= 0) return {sg, 31'b0};
    if (ev >= 255) return {sg, 8'hFF, 23'b0};
    return {sg, ev[7:0], fr};
  endfunction

  function automatic int model_lat(input int ones);
    if (ones == 0) return L + 1;
    return L + (N - ($clog2(ones + 1) - 1)) + 1;
  endfunction

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("result_P", P, x.p);
        check("latency", 32'(edge_cnt - x.start_edge), 32'(x.lat));
        last_p = x.p;
      end
    end
    done_q = done;
  end

  task automatic convert(input logic sg, input logic [7:0] ex, input int abort_at,
                         input int glitch_at, input int stall_at, input int stall_len);
    int   ones;
    exp_t x;
    int   waited;
    ones = 0;
    for (int i = 0; i < L; i++) ones += int'(stream[i]);
    @(negedge clk);
    x.p          = model(sg, ex, ones);
    x.lat        = model_lat(ones) + stall_len;
    x.start_edge = edge_cnt + 1;
    sb.push_back(x);
    start   = 1'b1;
    sign_in = sg;
    exp_in  = ex;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("P_hold_after_start", P, last_p);
        check("done_low_after_start", 32'(done), 32'd0);
      end
      start   = (i == glitch_at);
      sign_in = 1'($urandom);
      exp_in  = 8'($urandom);
`ifdef SC_DEC_STALL_EN
      if (i == stall_at) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        repeat (stall_len) @(negedge clk);
        bit_valid = 1'b1;
      end
`else
      if (stall_at < 0 && stall_len != 0) check("stall_unsupported", 32'd1, 32'd0);
`endif
      bit_in = stream[i];
      if (i == abort_at) begin
        void'(sb.pop_back());
        rst = 1'b0;
        #1;
        check("abort_P", P, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        last_p = 32'd0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        return;
      end
    end
    @(negedge clk);
    start  = 1'b0;
    bit_in = 1'($urandom);
    waited = 0;
    while (sb.size() != 0 && waited < 2 * L) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(waited), 32'd0);
      sb.delete();
    end
  endtask

  task automatic fill_const(input logic v);
    for (int i = 0; i < L; i++) stream[i] = v;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_P", P, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b1;

    fill_const(1'b1);
    convert(1'b0, 8'd127, -1, -1, -1, 0);
    for (int i = 0; i < L; i++) stream[i] = (i % 2 == 0);
    convert(1'b0, 8'd127, -1, -1, -1, 0);
    for (int i = 0; i < L; i++) stream[i] = (i < 3);
    convert(1'b0, 8'd127, -1, -1, -1, 0);
    fill_const(1'b0);
    convert(1'b1, 8'd127, -1, -1, -1, 0);
    for (int i = 0; i < L; i++) stream[i] = (i == 17);
    convert(1'b0, 8'd3, -1, -1, -1, 0);
    fill_const(1'b1);
    convert(1'b0, 8'd254, -1, -1, -1, 0);

    for (int i = 0; i < L; i++) stream[i] = 1'($urandom);
    convert(1'b1, 8'd130, 49, -1, -1, 0);
    convert(1'b1, 8'd130, -1, 100, -1, 0);

`ifdef SC_DEC_STALL_EN
    fill_const(1'b1);
    convert(1'b0, 8'd127, -1, -1, 40, 10);
`endif

    for (int t = 0; t < 10; t++) begin
      int thr;
      thr = $urandom_range(0, 256);
      for (int i = 0; i < L; i++) stream[i] = ($urandom_range(0, 255) < thr);
      convert(1'($urandom), 8'($urandom_range(1, 254)), -1, -1, -1, 0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
    $fatal(1);
  end

endmodule
